count_step_monitor: RTL and testbench



---
 rtl/count_step_monitor_pkg.sv | 35 +++
 rtl/count_step_monitor_sat_counter.sv | 26 ++
 rtl/count_step_monitor.sv | 132 +++++++++++++
 tb/tb_count_step_monitor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/count_step_monitor_pkg.sv
// Shared definitions for the counter step monitor: state encodings,
// direction encodings, count width and the next-value prediction.
package count_step_monitor_pkg;

  // Width of the counter under check, common with the counter itself.
  localparam int CNT_W = 3;

  // Counter direction encodings as seen on the mode input.
  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

  // Monitor FSM states; encoding is visible on the state output.
  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2,
    ALARM  = 2'd3
  } state_t;

  // Value the counter must show this cycle, given what drove it last cycle.
  // A load wins over counting; counting wraps modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] next_exp(
    input logic [CNT_W-1:0] prev_count,
    input logic             prev_mode,
    input logic             prev_set,
    input logic [CNT_W-1:0] prev_setnum
  );
    logic [CNT_W-1:0] val;
    if (prev_set)                val = prev_setnum;
    else if (prev_mode == MODE_UP) val = prev_count + CNT_W'(1);
    else                         val = prev_count - CNT_W'(1);
    return val;
  endfunction

endpackage

// File: rtl/count_step_monitor_sat_counter.sv
// W-bit saturating event counter. Sticks at all-ones, holds while frozen,
// clears synchronously.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         freeze_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count increments unless frozen or already saturated.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !freeze_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_step_monitor.sv
// Step checker for a 3-bit up/down/loadable counter. Predicts each count
// from the previous cycle's count and controls, flags wraps and illegal
// steps with one-cycle pulses, keeps event counters, and latches an alarm
// once the error count reaches ERR_LIMIT.
//
// Handshake: none. The monitor samples count/mode/set/setnum on every
// rising edge unconditionally; all outputs are registered and describe the
// edge that sampled the offending or wrapping count (1-cycle latency).
module count_step_monitor
  import count_step_monitor_pkg::*;
#(
  parameter int WCNT      = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CNT_W-1:0] count,
  input  logic             mode,
  input  logic             set,
  input  logic [CNT_W-1:0] setnum,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             step_err,
  output logic [CNT_W-1:0] bad_val,
  output logic [CNT_W-1:0] exp_val,
  output logic [WCNT-1:0]  wrap_cnt,
  output logic [WCNT-1:0]  err_cnt,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam logic [WCNT:0]    LIMIT = ERR_LIMIT[WCNT:0];
  localparam logic [CNT_W-1:0] TOP   = {CNT_W{1'b1}};

  state_t           state_q;
  logic [CNT_W-1:0] prev_count_q, prev_setnum_q;
  logic             prev_mode_q, prev_set_q;
  logic             wrap_up_q, wrap_dn_q, step_err_q, alarm_q;
  logic [CNT_W-1:0] bad_val_q, exp_val_q;

  logic [CNT_W-1:0] exp_w;
  logic             tracking, match, is_wrap_up, is_wrap_dn, err_hit, limit_hit;
  logic [WCNT:0]    err_plus;

  // Prediction and classification of the step sampled at this edge.
  always_comb begin
    exp_w      = next_exp(prev_count_q, prev_mode_q, prev_set_q, prev_setnum_q);
    tracking   = (state_q == TRACK);
    match      = (count == exp_w);
    // A load that lands on 0 or 7 is not a wrap, hence the !prev_set term.
    is_wrap_up = !prev_set_q && (prev_mode_q == MODE_UP) &&
                 (prev_count_q == TOP) && (count == '0);
    is_wrap_dn = !prev_set_q && (prev_mode_q == MODE_DN) &&
                 (prev_count_q == '0) && (count == TOP);
    err_hit    = tracking && !match;
    err_plus   = {1'b0, err_cnt} + (WCNT + 1)'(1);
    limit_hit  = (err_plus == LIMIT);
  end

  sat_counter #(.W(WCNT)) u_wrap_cnt (
    .clk_i    (clk),
    .clr_i    (clr),
    .inc_i    (tracking && match && (is_wrap_up || is_wrap_dn)),
    .freeze_i (state_q == ALARM),
    .cnt_o    (wrap_cnt)
  );

  sat_counter #(.W(WCNT)) u_err_cnt (
    .clk_i    (clk),
    .clr_i    (clr),
    .inc_i    (err_hit),
    .freeze_i (state_q == ALARM),
    .cnt_o    (err_cnt)
  );

  // Monitor FSM: input capture, step check, registered pulses and alarm.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= PRIME;
      prev_count_q  <= '0;
      prev_mode_q   <= 1'b0;
      prev_set_q    <= 1'b0;
      prev_setnum_q <= '0;
      wrap_up_q     <= 1'b0;
      wrap_dn_q     <= 1'b0;
      step_err_q    <= 1'b0;
      bad_val_q     <= '0;
      exp_val_q     <= '0;
      alarm_q       <= 1'b0;
    end else begin
      // Inputs are captured in every state so RESYNC and PRIME re-anchor.
      prev_count_q  <= count;
      prev_mode_q   <= mode;
      prev_set_q    <= set;
      prev_setnum_q <= setnum;
      wrap_up_q     <= 1'b0;
      wrap_dn_q     <= 1'b0;
      step_err_q    <= 1'b0;
      case (state_q)
        PRIME:  state_q <= TRACK;
        RESYNC: state_q <= TRACK;
        TRACK: begin
          if (match) begin
            wrap_up_q <= is_wrap_up;
            wrap_dn_q <= is_wrap_dn;
          end else begin
            step_err_q <= 1'b1;
            bad_val_q  <= count;
            exp_val_q  <= exp_w;
            if (limit_hit) begin
              state_q <= ALARM;
              alarm_q <= 1'b1;
            end else begin
              state_q <= RESYNC;
            end
          end
        end
        ALARM:   state_q <= ALARM;
        default: state_q <= PRIME;
      endcase
    end
  end

  assign wrap_up  = wrap_up_q;
  assign wrap_dn  = wrap_dn_q;
  assign step_err = step_err_q;
  assign bad_val  = bad_val_q;
  assign exp_val  = exp_val_q;
  assign alarm    = alarm_q;
  assign state    = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor: a vector table covering reset,
// up/down wraps and loads, then hand-written error, alarm and clear sequences.
module tb_count_step_monitor;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [2:0] count = '0;
  logic       mode = 1'b0;
  logic       set = 1'b0;
  logic [2:0] setnum = '0;
  logic       wrap_up, wrap_dn, step_err, alarm;
  logic [2:0] bad_val, exp_val;
  logic [7:0] wrap_cnt, err_cnt;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       clr;
    logic [2:0] count;
    logic       mode;
    logic       set;
    logic [2:0] setnum;
    logic       wu;
    logic       wd;
    logic       se;
    logic [1:0] st;
    logic [7:0] wc;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  count_step_monitor #(.WCNT(8), .ERR_LIMIT(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .count    (count),
    .mode     (mode),
    .set      (set),
    .setnum   (setnum),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .step_err (step_err),
    .bad_val  (bad_val),
    .exp_val  (exp_val),
    .wrap_cnt (wrap_cnt),
    .err_cnt  (err_cnt),
    .alarm    (alarm),
    .state    (state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic void add(input logic c_clr, input logic [2:0] c, input logic m,
                              input logic s, input logic [2:0] sn, input logic wu,
                              input logic wd, input logic se, input logic [1:0] st,
                              input logic [7:0] wc, input logic [7:0] ec);
    vec_t v;
    v.clr = c_clr; v.count = c; v.mode = m; v.set = s; v.setnum = sn;
    v.wu = wu; v.wd = wd; v.se = se; v.st = st; v.wc = wc; v.ec = ec;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then settle past the sampling edge.
  task automatic drive(input logic c_clr, input logic [2:0] c, input logic m,
                       input logic s, input logic [2:0] sn);
    @(negedge clk);
    clr = c_clr; count = c; mode = m; set = s; setnum = sn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic wu, input logic wd,
                            input logic se, input logic [1:0] st, input logic [7:0] wc,
                            input logic [7:0] ec, input logic [2:0] bv,
                            input logic [2:0] ev);
    chk({tag, ".wrap_up"},  wrap_up,  wu);
    chk({tag, ".wrap_dn"},  wrap_dn,  wd);
    chk({tag, ".step_err"}, step_err, se);
    chk({tag, ".state"},    state,    st);
    chk({tag, ".wrap_cnt"}, wrap_cnt, wc);
    chk({tag, ".err_cnt"},  err_cnt,  ec);
    chk({tag, ".bad_val"},  bad_val,  bv);
    chk({tag, ".exp_val"},  exp_val,  ev);
    chk({tag, ".alarm"},    alarm,    (st == 2'd3));
  endtask

  initial begin
    // Reset held two cycles, then priming cycle.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // 16 free-running up steps: wraps at step 8 and 16.
    for (int k = 1; k <= 16; k++)
      add(0, 3'(k % 8), 0, 0, 0, (k == 8 || k == 16), 0, 0, 1,
          (k >= 16) ? 8'd2 : (k >= 8) ? 8'd1 : 8'd0, 0);
    // Load 3 then count down through 0->7.
    add(0, 1, 1, 1, 3, 0, 0, 0, 1, 2, 0);
    add(0, 3, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    add(0, 2, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    add(0, 7, 1, 0, 0, 0, 1, 0, 1, 3, 0);
    add(0, 6, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 5, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 4, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    // At count 2 request a load of 5 in up mode.
    add(0, 2, 0, 1, 5, 0, 0, 0, 1, 3, 0);
    add(0, 5, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 6, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    // At 7 in up mode load 0: landing on 0 is not a wrap.
    add(0, 7, 0, 1, 0, 0, 0, 0, 1, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 2, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].count, tbl[i].mode, tbl[i].set, tbl[i].setnum);
      expect_out($sformatf("vec%0d", i), tbl[i].wu, tbl[i].wd, tbl[i].se, tbl[i].st,
                 tbl[i].wc, tbl[i].ec, 3'd0, 3'd0);
    end

    // Single bad step: 6 where 4 is expected, then one RESYNC cycle.
    drive(0, 6, 0, 0, 0); expect_out("err1",    0, 0, 1, 2, 3, 1, 6, 4);
    drive(0, 7, 0, 0, 0); expect_out("resync1", 0, 0, 0, 1, 3, 1, 6, 4);
    drive(0, 0, 0, 0, 0); expect_out("wrap4",   1, 0, 0, 1, 4, 1, 6, 4);

    // Errors 2 and 3, each followed by resync and a good step.
    drive(0, 3, 0, 0, 0); expect_out("err2",    0, 0, 1, 2, 4, 2, 3, 1);
    drive(0, 4, 0, 0, 0); expect_out("resync2", 0, 0, 0, 1, 4, 2, 3, 1);
    drive(0, 5, 0, 0, 0); expect_out("ok2",     0, 0, 0, 1, 4, 2, 3, 1);
    drive(0, 0, 0, 0, 0); expect_out("err3",    0, 0, 1, 2, 4, 3, 0, 6);
    drive(0, 1, 0, 0, 0); expect_out("resync3", 0, 0, 0, 1, 4, 3, 0, 6);
    drive(0, 2, 0, 0, 0); expect_out("ok3",     0, 0, 0, 1, 4, 3, 0, 6);

    // Fourth error reaches the limit and enters ALARM in the same cycle.
    drive(0, 7, 0, 0, 0); expect_out("err4",    0, 0, 1, 3, 4, 4, 7, 3);
    // In ALARM a would-be wrap and a bad step change nothing.
    drive(0, 0, 0, 0, 0); expect_out("alarm_w", 0, 0, 0, 3, 4, 4, 7, 3);
    drive(0, 5, 0, 0, 0); expect_out("alarm_e", 0, 0, 0, 3, 4, 4, 7, 3);

    // Clear out of ALARM.
    drive(1, 5, 0, 0, 0); expect_out("clr_alm", 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear during RESYNC.
    drive(0, 0, 0, 0, 0); expect_out("prime2",  0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0); expect_out("ok4",     0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 5, 0, 0, 0); expect_out("err5",    0, 0, 1, 2, 0, 1, 5, 2);
    drive(1, 6, 0, 0, 0); expect_out("clr_rsy", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
